// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier, P = MC*MP (+ AD when MUL8_ADD_EN is defined).
// One multiplier bit per clock; start/busy/done handshake, 9 clocks from start edge to done.
module mul8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  MC,
  input  logic [7:0]  MP,
`ifdef MUL8_ADD_EN
  input  logic [7:0]  AD,
`endif
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [15:0] r_p;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;
  logic [15:0] w_acc_init;
  logic [15:0] w_acc_sum;
  logic        w_load;
  logic        w_last;

`ifdef MUL8_ADD_EN
  assign w_acc_init = {8'h00, AD};
`else
  assign w_acc_init = '0;
`endif

  assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign P         = r_p;

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    w_load = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (r_cnt == 3'd7) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load = 1'b1;
          w_next = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_acc    <= w_acc_init;
        r_mcand  <= {8'h00, MC};
        r_mplier <= MP;
        r_cnt    <= '0;
      end else if (r_state == BUSY) begin
        r_acc    <= w_acc_sum;
        r_mcand  <= {r_mcand[14:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[7:1]};
        r_cnt    <= r_cnt + 3'd1;
      end
      // The final bit's partial product goes straight into P on the last BUSY edge.
      if (w_last) begin
        r_p <= w_acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboard bench for mul8_seq: a cycle-level acceptance model pushes expected results,
// a monitor pops them on done and also checks busy/done/P every cycle.
module tb_mul8_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mc;
  logic [7:0]  mp;
  logic [7:0]  ad;
  logic [15:0] p;
  logic        busy;
  logic        done;

  mul8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .MC    (mc),
    .MP    (mp),
`ifdef MUL8_ADD_EN
    .AD    (ad),
`endif
    .P     (p),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_no = 0;
  int          acc_edge = 0;
  int          busy_until = -1;
  logic [15:0] pend_p = '0;
  logic [15:0] exp_p = '0;

  function automatic logic [15:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
    int unsigned r;
    r = int'(a) * int'(b);
`ifdef MUL8_ADD_EN
    r = r + int'(c);
`endif
    return r[15:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endtask

  // Reference model: a request is accepted whenever the previous one has produced
  // its result; the result lands 8 edges after acceptance.
  initial forever begin
    @(posedge clk);
    edge_no++;
    if (rst) begin
      busy_until = -1;
      acc_edge   = 0;
      exp_p      = '0;
      sb_q.delete();
    end else begin
      if (edge_no == busy_until) exp_p = pend_p;
      if (start && edge_no > busy_until) begin
        acc_edge   = edge_no;
        busy_until = edge_no + 8;
        pend_p     = ref_result(mc, mp, ad);
        sb_q.push_back('{p: pend_p, due: busy_until});
      end
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    check("busy", int'(busy), int'(edge_no >= acc_edge && edge_no < busy_until));
    check("done", int'(done), int'(edge_no == busy_until));
    check("P_hold", int'(p), int'(exp_p));
    if (done) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("P_result", int'(p), int'(e.p));
        check("done_edge", edge_no, e.due);
      end
    end
  end

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    mc = a; mp = b; ad = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mc = '0; mp = '0; ad = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    op(8'd13, 8'd19, 8'd5);
    op(8'd255, 8'd255, 8'd255);

    // Operand changes and a start pulse mid-operation must be ignored.
    @(negedge clk);
    mc = 8'd0; mp = 8'd200; ad = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mc = 8'd99; mp = 8'd99; ad = 8'd99;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back with start held high through the done cycle.
    @(negedge clk);
    mc = 8'd3; mp = 8'd4; ad = 8'd1; start = 1'b1;
    @(negedge clk);
    mc = 8'd10; mp = 8'd10; ad = 8'd0;
    repeat (9) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during the 4th busy cycle aborts the operation.
    @(negedge clk);
    mc = 8'd100; mp = 8'd2; ad = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       begin mc = 8'hFF; mp = 8'hFF; ad = 8'hFF; end
        1:       begin mc = 8'h00; mp = 8'($urandom); ad = 8'($urandom); end
        default: begin mc = 8'($urandom); mp = 8'($urandom); ad = 8'($urandom); end
      endcase
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (12) @(negedge clk);
    check("queue_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul8_seq.md
# mul8_seq

Sequential 8-bit unsigned shift-add multiply-accumulate unit computing P = MC × MP + AD, the inverse of the 8-bit array divider (Q × SC + R reconstructs SBC). It sits beside the divider as its reconstruction path and as a self-check engine: feeding it the divider's Q, SC and R must return the original dividend. It processes one multiplier bit per clock under a start/busy/done handshake.

## Interface
- No parameters; width fixed at 8-bit operands, 16-bit product.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled on a rising edge while idle or done
- MC  input  8  multiplicand (unsigned); sampled with start
- MP  input  8  multiplier (unsigned); sampled with start
- AD  input  8  addend (unsigned), zero-extended to 16 bits; sampled with start; present only with MUL8_ADD_EN
- P  output  16  result register; holds last completed result
- busy  output  1  high while a multiplication is in progress
- done  output  1  one-cycle pulse, high in the cycle P first shows a new result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: busy=0, done=0. start=1 → load acc = {8'b0, AD}, mcand = {8'b0, MC}, mplier = MP, cnt = 0; go BUSY.
- BUSY: busy=1. Each cycle: if mplier[0], acc = acc + mcand (16-bit); mcand <<= 1; mplier >>= 1; cnt++. After the 8th BUSY cycle (cnt reaches 7 at the edge) go DONE and load P with final acc.
- DONE: done=1, busy=0, P valid. start=1 in DONE is accepted exactly as in IDLE (back-to-back); otherwise return to IDLE.
- start while BUSY: ignored; no operand resampling, no effect on current result.
- Operands need only be stable on the start edge; internal copies are used thereafter.
- Arithmetic: all unsigned. Maximum result 255×255+255 = 65280 < 2^16; no overflow possible, no overflow flag.
- No early termination: always exactly 8 BUSY cycles, including MP=0 or MC=0.
- P changes only on entry to DONE or on reset; holds between operations.

## Timing
- Reset values: state=IDLE, P=16'h0000, busy=0, done=0, internal registers zero.
- rst dominates every other input in the same cycle; reset mid-operation aborts, no done pulse, P=0.
- Start sampled at edge k → busy high for cycles after edges k..k+7 → edge k+8 loads P, done high for the cycle after edge k+8. Latency start edge to done = 9 clocks.
- Back-to-back: start in the done cycle sampled at edge k+9 → busy again after k+9; throughput one result per 9 clocks.
- done is never high two consecutive cycles except on back-to-back completions separated by 9 clocks (never adjacent).

## Configuration
- MUL8_ADD_EN defined: AD port exists; P = MC×MP + AD (divider reconstruction mode).
- MUL8_ADD_EN undefined: AD port absent; acc loads 16'h0000; P = MC×MP. Timing, states and handshake identical.

## Test plan
- Reset, then idle 5 cycles → P=0x0000, busy=0, done=0 throughout.
- MC=13, MP=19, AD=5, start 1 cycle → busy 8 cycles, done pulse on 9th clock, P=252 (0x00FC), held after done.
- MC=255, MP=255, AD=255 → P=65280 (0xFF00); without MUL8_ADD_EN → P=65025 (0xFE01).
- MC=0, MP=200, AD=7 → still 8 busy cycles, P=7; change operands and pulse start during busy → ignored, result unchanged.
- Back-to-back: start held high through done cycle with MC=3, MP=4, AD=1 then MC=10, MP=10, AD=0 → P=13 then P=100, done pulses 9 clocks apart.
- Assert rst at 4th busy cycle of MC=100, MP=2 → next cycle busy=0, done=0, P=0; no done pulse follows.
